// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline main control: opcode/func encodings,
// ALU operation and operand-source codes, destination select, the decoded
// control bundle carried down the pipe, and the all-zero BUBBLE bundle.
package ctrl_pkg;

  // Opcode field values (instr[31:26]) understood by the decoder
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_STOP  = 6'd63;

  // Function field values (instr[5:0]) for R-type instructions
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_SLLV = 6'd4;
  localparam logic [5:0] FN_SRLV = 6'd6;
  localparam logic [5:0] FN_SRAV = 6'd7;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;

  // Native widths of the bundle fields; wider ports are zero-extended
  localparam int ALU_CTRL_MIN_W = 4;
  localparam int ALU_SRC_MIN_W  = 3;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_RT       = 3'd0,
    SRC_ZEXT_IMM = 3'd1,
    SRC_SEXT_IMM = 3'd2,
    SRC_RS_SHAMT = 3'd3,
    SRC_SHAMT    = 3'd4
  } alu_src_e;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fsm_state_e;

  // Full decoded control, as held in the EX stage register
  typedef struct packed {
    alu_op_e  alu_ctrl;
    alu_src_e alu_src;
    reg_dst_e reg_dst;
    logic     beq;
    logic     bne;
    logic     jump;
    logic     jr;
    logic     mem_write;
    logic     mem2reg;
    logic     reg_write;
    logic     link;
  } ctrl_bundle_t;

  // Only the fields still needed downstream travel past EX
  typedef struct packed {
    logic mem_write;
    logic mem2reg;
    logic reg_write;
    logic link;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem2reg;
    logic link;
  } wb_ctrl_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/func to control bundle, plus
// illegal-encoding and STOP detection. STOP decodes to a bubble bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   func_i,
  output ctrl_bundle_t ctrl_o,
  output logic         illegal_o,
  output logic         is_stop_o
);

  // Decode table; unknown encodings leave the bundle at BUBBLE and flag illegal
  always_comb begin
    ctrl_o    = BUBBLE;
    illegal_o = 1'b0;
    is_stop_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = DST_RD;
        unique case (func_i)
          FN_ADD, FN_ADDU: ctrl_o.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl_o.alu_ctrl = ALU_SUB;
          FN_AND:          ctrl_o.alu_ctrl = ALU_AND;
          FN_OR:           ctrl_o.alu_ctrl = ALU_OR;
          FN_XOR:          ctrl_o.alu_ctrl = ALU_XOR;
          FN_NOR:          ctrl_o.alu_ctrl = ALU_NOR;
          FN_SLT:          ctrl_o.alu_ctrl = ALU_SLT;
          FN_SLL: begin
            ctrl_o.alu_ctrl = ALU_SLL;
            ctrl_o.alu_src  = SRC_SHAMT;
          end
          FN_SRL: begin
            ctrl_o.alu_ctrl = ALU_SRL;
            ctrl_o.alu_src  = SRC_SHAMT;
          end
          FN_SRA: begin
            ctrl_o.alu_ctrl = ALU_SRA;
            ctrl_o.alu_src  = SRC_SHAMT;
          end
          FN_SLLV: begin
            ctrl_o.alu_ctrl = ALU_SLL;
            ctrl_o.alu_src  = SRC_RS_SHAMT;
          end
          FN_SRLV: begin
            ctrl_o.alu_ctrl = ALU_SRL;
            ctrl_o.alu_src  = SRC_RS_SHAMT;
          end
          FN_SRAV: begin
            ctrl_o.alu_ctrl = ALU_SRA;
            ctrl_o.alu_src  = SRC_RS_SHAMT;
          end
          FN_JR: begin
            ctrl_o    = BUBBLE;
            ctrl_o.jr = 1'b1;
          end
          default: begin
            ctrl_o    = BUBBLE;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = DST_RA;
        ctrl_o.link      = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_ctrl = ALU_SUB;
        ctrl_o.beq      = 1'b1;
      end
      OP_BNE: begin
        ctrl_o.alu_ctrl = ALU_SUB;
        ctrl_o.bne      = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.alu_src   = SRC_SEXT_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl_o.alu_ctrl  = ALU_AND;
        ctrl_o.alu_src   = SRC_ZEXT_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      OP_ORI: begin
        ctrl_o.alu_ctrl  = ALU_OR;
        ctrl_o.alu_src   = SRC_ZEXT_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      OP_XORI: begin
        ctrl_o.alu_ctrl  = ALU_XOR;
        ctrl_o.alu_src   = SRC_ZEXT_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_src   = SRC_SEXT_IMM;
        ctrl_o.mem2reg   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = SRC_SEXT_IMM;
        ctrl_o.mem_write = 1'b1;
      end
      OP_STOP: is_stop_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Main pipeline control: decoder, EX/MEM/WB control registers, bubble
// insertion, illegal pulse and the STOP drain-and-halt FSM.
// Optional macro PIPE_CTRL_PERF_EN adds saturating retired/bubble counters.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int ALU_SRC_W  = 3,
  parameter int DRAIN_CYC  = 3
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W    = 32
`endif
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [5:0]            opcode,
  input  logic [5:0]            func,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  fetch_en,
  output logic                  halted,
  output logic                  illegal,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic [ALU_SRC_W-1:0]  ex_alu_src,
  output logic [1:0]            ex_reg_dst,
  output logic                  ex_beq,
  output logic                  ex_bne,
  output logic                  ex_jump,
  output logic                  ex_jr,
  output logic                  mem_mem_write,
  output logic                  mem_mem2reg,
  output logic                  wb_reg_write,
  output logic                  wb_mem2reg,
  output logic                  wb_link
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  ctrl_bundle_t        dec_ctrl;
  logic                dec_illegal;
  logic                dec_stop;
  logic                id_ok;
  logic                capture;
  logic                stop_take;

  ctrl_bundle_t        ex_q;
  mem_ctrl_t           mem_q;
  wb_ctrl_t            wb_q;
  logic                illegal_q;
  fsm_state_e          state_q, state_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;

  ctrl_decode u_decode (
    .opcode_i  (opcode),
    .func_i    (func),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .is_stop_o (dec_stop)
  );

  // An ID instruction is acted on only when valid, not held or squashed, and running
  assign id_ok     = instr_valid && !stall && !flush && (state_q == ST_RUN);
  assign capture   = id_ok && !dec_illegal && !dec_stop;
  assign stop_take = id_ok && dec_stop;

  // Stage registers: EX takes the decode or a bubble, MEM/WB always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= BUBBLE;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q            <= capture ? dec_ctrl : BUBBLE;
      mem_q.mem_write <= ex_q.mem_write;
      mem_q.mem2reg   <= ex_q.mem2reg;
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.link      <= ex_q.link;
      wb_q.reg_write  <= mem_q.reg_write;
      wb_q.mem2reg    <= mem_q.mem2reg;
      wb_q.link       <= mem_q.link;
      illegal_q       <= id_ok && dec_illegal;
    end
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state: RUN -> DRAIN on an accepted STOP, DRAIN -> HALTED after DRAIN_CYC edges
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (stop_take) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  assign fetch_en      = (state_q == ST_RUN);
  assign halted        = (state_q == ST_HALTED);
  assign illegal       = illegal_q;
  assign ex_alu_ctrl   = ALU_CTRL_W'(ex_q.alu_ctrl);
  assign ex_alu_src    = ALU_SRC_W'(ex_q.alu_src);
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_beq        = ex_q.beq;
  assign ex_bne        = ex_q.bne;
  assign ex_jump       = ex_q.jump;
  assign ex_jr         = ex_q.jr;
  assign mem_mem_write = mem_q.mem_write;
  assign mem_mem2reg   = mem_q.mem2reg;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem2reg    = wb_q.mem2reg;
  assign wb_link       = wb_q.link;

`ifdef PIPE_CTRL_PERF_EN
  logic             mem_live_q;
  logic             wb_live_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] bubble_q;

  // Saturating counters; live bits follow each real instruction to WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_live_q <= 1'b0;
      wb_live_q  <= 1'b0;
      retired_q  <= '0;
      bubble_q   <= '0;
    end else begin
      mem_live_q <= (ex_q != BUBBLE);
      wb_live_q  <= mem_live_q;
      if ((state_q != ST_HALTED) && wb_live_q && (retired_q != '1)) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if ((state_q == ST_RUN) && !capture && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign retired_cnt = retired_q;
  assign bubble_cnt  = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus a random
// run against an instruction-level reference model of the control pipe.
module tb_pipe_ctrl_unit;

  localparam int DRAIN = 3;
  localparam int CMAX  = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       fetch_en, halted, illegal;
  logic [3:0] ex_alu_ctrl;
  logic [2:0] ex_alu_src;
  logic [1:0] ex_reg_dst;
  logic       ex_beq, ex_bne, ex_jump, ex_jr;
  logic       mem_mem_write, mem_mem2reg;
  logic       wb_reg_write, wb_mem2reg, wb_link;
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0] retired_cnt, bubble_cnt;
`endif

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] src;
    logic [1:0] dst;
    logic beq, bne, jump, jr, mw, m2r, rw, link;
  } exp_t;

  exp_t m_ex, m_mem, m_wb;
  bit   m_ill, m_run;
  int   m_edges, m_ret, m_bub;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_unit #(.ALU_CTRL_W(4), .ALU_SRC_W(3), .DRAIN_CYC(DRAIN), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .func(func),
    .stall(stall), .flush(flush), .fetch_en(fetch_en), .halted(halted), .illegal(illegal),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_jr(ex_jr),
    .mem_mem_write(mem_mem_write), .mem_mem2reg(mem_mem2reg),
    .wb_reg_write(wb_reg_write), .wb_mem2reg(wb_mem2reg), .wb_link(wb_link),
    .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
  );
`else
  pipe_ctrl_unit #(.ALU_CTRL_W(4), .ALU_SRC_W(3), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .func(func),
    .stall(stall), .flush(flush), .fetch_en(fetch_en), .halted(halted), .illegal(illegal),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_jr(ex_jr),
    .mem_mem_write(mem_mem_write), .mem_mem2reg(mem_mem2reg),
    .wb_reg_write(wb_reg_write), .wb_mem2reg(wb_mem2reg), .wb_link(wb_link)
  );
`endif

  // Instruction semantics: what each mnemonic asks of the datapath
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     output exp_t b, output bit legal, output bit stp);
    b = '0;
    legal = 1'b1;
    stp = 1'b0;
    case (op)
      6'd0: begin
        b.rw = 1'b1;
        b.dst = 2'd1;
        case (fn)
          6'd32, 6'd33: b.alu = 4'd0;
          6'd34, 6'd35: b.alu = 4'd1;
          6'd36: b.alu = 4'd2;
          6'd37: b.alu = 4'd3;
          6'd38: b.alu = 4'd4;
          6'd39: b.alu = 4'd5;
          6'd42: b.alu = 4'd6;
          6'd0:  begin b.alu = 4'd7; b.src = 3'd4; end
          6'd2:  begin b.alu = 4'd8; b.src = 3'd4; end
          6'd3:  begin b.alu = 4'd9; b.src = 3'd4; end
          6'd4:  begin b.alu = 4'd7; b.src = 3'd3; end
          6'd6:  begin b.alu = 4'd8; b.src = 3'd3; end
          6'd7:  begin b.alu = 4'd9; b.src = 3'd3; end
          6'd8:  begin b = '0; b.jr = 1'b1; end
          default: begin b = '0; legal = 1'b0; end
        endcase
      end
      6'd2:  b.jump = 1'b1;
      6'd3:  begin b.jump = 1'b1; b.rw = 1'b1; b.dst = 2'd2; b.link = 1'b1; end
      6'd4:  begin b.alu = 4'd1; b.beq = 1'b1; end
      6'd5:  begin b.alu = 4'd1; b.bne = 1'b1; end
      6'd8, 6'd9: begin b.src = 3'd2; b.rw = 1'b1; end
      6'd12: begin b.alu = 4'd2; b.src = 3'd1; b.rw = 1'b1; end
      6'd13: begin b.alu = 4'd3; b.src = 3'd1; b.rw = 1'b1; end
      6'd14: begin b.alu = 4'd4; b.src = 3'd1; b.rw = 1'b1; end
      6'd35: begin b.src = 3'd2; b.m2r = 1'b1; b.rw = 1'b1; end
      6'd43: begin b.src = 3'd2; b.mw = 1'b1; end
      6'd63: stp = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [12:0] ex_obs();
    return {ex_alu_ctrl, ex_alu_src, ex_reg_dst, ex_beq, ex_bne, ex_jump, ex_jr};
  endfunction

  function automatic logic [12:0] ex_exp();
    return {m_ex.alu, m_ex.src, m_ex.dst, m_ex.beq, m_ex.bne, m_ex.jump, m_ex.jr};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic st, input logic fl);
    instr_valid = v;
    opcode = op;
    func = fn;
    stall = st;
    flush = fl;
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_ill = 1'b0; m_run = 1'b1;
    m_edges = 0; m_ret = 0; m_bub = 0;
  endtask

  // Advance the reference model by one clock using the current inputs, then clock the DUT
  task automatic tick();
    exp_t d;
    bit legal, stp, act, cap, was_halted;
    ref_decode(opcode, func, d, legal, stp);
    act = instr_valid && !stall && !flush && m_run;
    cap = act && legal && !stp;
    was_halted = !m_run && (m_edges >= 1 + DRAIN);
    if (!was_halted && (m_wb != '0) && m_ret < CMAX) m_ret++;
    if (m_run && !cap && m_bub < CMAX) m_bub++;
    m_wb = m_mem;
    m_mem = m_ex;
    m_ex = cap ? d : '0;
    m_ill = act && !legal;
    if (m_run) begin
      if (act && stp) begin
        m_run = 1'b0;
        m_edges = 1;
      end
    end else begin
      m_edges++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    drive(1'b1, 6'd0, 6'd32, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {fetch_en, halted, illegal, ex_obs(), mem_mem_write, mem_mem2reg,
           wb_reg_write, wb_mem2reg, wb_link};
    n_checks++;
    if (obs !== 21'h100000) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, 21'h100000);
    end
    model_reset();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_add();
    do_reset();
    drive(1'b1, 6'd0, 6'd32, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({ex_alu_ctrl, ex_reg_dst} !== {4'd0, 2'd1}) begin
      n_fail++;
      $display("[TB] FAIL add_ex: got alu=%0d dst=%0d expected alu=0 dst=1", ex_alu_ctrl, ex_reg_dst);
    end
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++;
    if ({wb_reg_write, wb_mem2reg} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL add_wb: got rw=%b m2r=%b expected rw=1 m2r=0", wb_reg_write, wb_mem2reg);
    end
  endtask

  task automatic test_lw_stall();
    do_reset();
    drive(1'b1, 6'd35, 6'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ex_alu_src !== 3'd2) begin
      n_fail++;
      $display("[TB] FAIL lw_ex: got src=%0d expected 2", ex_alu_src);
    end
    drive(1'b1, 6'd0, 6'd34, 1'b1, 1'b0);
    tick();
    n_checks++;
    if ({ex_obs(), mem_mem2reg} !== {13'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL lw_stall_bubble: got ex=%h m2r=%b expected ex=0 m2r=1", ex_obs(), mem_mem2reg);
    end
    drive(1'b1, 6'd0, 6'd34, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({ex_alu_ctrl, ex_reg_dst} !== {4'd1, 2'd1}) begin
      n_fail++;
      $display("[TB] FAIL lw_stall_release: got alu=%0d dst=%0d expected alu=1 dst=1", ex_alu_ctrl, ex_reg_dst);
    end
  endtask

  task automatic test_jal_flush();
    do_reset();
    drive(1'b1, 6'd3, 6'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({ex_jump, ex_reg_dst} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("[TB] FAIL jal_ex: got jump=%b dst=%0d expected jump=1 dst=2", ex_jump, ex_reg_dst);
    end
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++;
    if ({wb_link, wb_reg_write} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL jal_wb: got link=%b rw=%b expected 1 1", wb_link, wb_reg_write);
    end
    drive(1'b1, 6'd3, 6'd0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if ({ex_obs(), illegal} !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL jal_flush: got ex=%h illegal=%b expected all zero", ex_obs(), illegal);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 6'd20, 6'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({illegal, ex_obs()} !== {1'b1, 13'd0}) begin
      n_fail++;
      $display("[TB] FAIL illegal_pulse: got ill=%b ex=%h expected ill=1 ex=0", illegal, ex_obs());
    end
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL illegal_one_cycle: got %b expected 0", illegal);
    end
    drive(1'b1, 6'd20, 6'd0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL illegal_flushed: got %b expected 0", illegal);
    end
  endtask

  task automatic test_stop();
    do_reset();
    drive(1'b1, 6'd43, 6'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd63, 6'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({fetch_en, halted, mem_mem_write} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL stop_accept: got fetch=%b halted=%b mw=%b expected 0 0 1", fetch_en, halted, mem_mem_write);
    end
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    for (int i = 2; i <= DRAIN + 1; i++) begin
      tick();
      n_checks++;
      if (halted !== (i == DRAIN + 1)) begin
        n_fail++;
        $display("[TB] FAIL stop_drain edge %0d: got halted=%b expected %b", i, halted, (i == DRAIN + 1));
      end
    end
    do_reset();
    drive(1'b1, 6'd63, 6'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fetch_en, halted} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL reset_in_drain: got fetch=%b halted=%b expected 1 0", fetch_en, halted);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [5:0] ops[14] = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9,
                            6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
    logic [5:0] fns[16] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd32,
                            6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
    logic [5:0] op, fn;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 62)) : ops[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 15)];
      drive($urandom_range(0, 9) < 8, op, fn, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      tick();
      n_checks += 4;
      if (ex_obs() !== ex_exp()) begin
        n_fail++;
        $display("[TB] FAIL rand_ex cyc %0d: got %h expected %h", c, ex_obs(), ex_exp());
      end
      if ({mem_mem_write, mem_mem2reg} !== {m_mem.mw, m_mem.m2r}) begin
        n_fail++;
        $display("[TB] FAIL rand_mem cyc %0d: got %b%b expected %b%b", c, mem_mem_write, mem_mem2reg, m_mem.mw, m_mem.m2r);
      end
      if ({wb_reg_write, wb_mem2reg, wb_link} !== {m_wb.rw, m_wb.m2r, m_wb.link}) begin
        n_fail++;
        $display("[TB] FAIL rand_wb cyc %0d: got %b%b%b expected %b%b%b", c, wb_reg_write, wb_mem2reg, wb_link, m_wb.rw, m_wb.m2r, m_wb.link);
      end
      if ({illegal, fetch_en} !== {m_ill, m_run}) begin
        n_fail++;
        $display("[TB] FAIL rand_flags cyc %0d: got ill=%b fetch=%b expected %b %b", c, illegal, fetch_en, m_ill, m_run);
      end
`ifdef PIPE_CTRL_PERF_EN
      n_checks++;
      if ({retired_cnt, bubble_cnt} !== {4'(m_ret), 4'(m_bub)}) begin
        n_fail++;
        $display("[TB] FAIL rand_perf cyc %0d: got ret=%0d bub=%0d expected %0d %0d", c, retired_cnt, bubble_cnt, m_ret, m_bub);
      end
`endif
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf_saturate();
    do_reset();
    drive(1'b1, 6'd0, 6'd32, 1'b0, 1'b0);
    repeat (20) tick();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (retired_cnt !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL perf_retired_sat: got %0d expected 15", retired_cnt);
    end
    n_checks++;
    if (bubble_cnt !== 4'(m_bub)) begin
      n_fail++;
      $display("[TB] FAIL perf_bubble: got %0d expected %0d", bubble_cnt, m_bub);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_lw_stall();
    test_jal_flush();
    test_illegal();
    test_stop();
    test_random();
`ifdef PIPE_CTRL_PERF_EN
    test_perf_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
